// File: rtl/phy_tx_sched_pkg.sv
// Shared definitions for the two-lane TX scheduler: link state encoding,
// default fill symbols and a one-hot to index helper.
package phy_tx_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_ACTIVE   = 2'd2
  } link_state_e;

  localparam logic [7:0] COM_SYM_DEF = 8'hBC;
  localparam logic [7:0] IDL_SYM_DEF = 8'h7C;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/phy_tx_sched_rr_pick2.sv
// Round-robin picker: scans four requesters starting at ptr and returns the
// first two requesting sources as one-hot grants with valid flags.
module rr_pick2 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt0,
  output logic [3:0] gnt1,
  output logic       vld0,
  output logic       vld1
);

  logic [1:0] idx_s;

  // Priority scan from ptr upwards, wrapping through the 2-bit index.
  always_comb begin
    gnt0  = 4'b0000;
    gnt1  = 4'b0000;
    vld0  = 1'b0;
    vld1  = 1'b0;
    idx_s = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx_s = ptr + k[1:0];
      if (req[idx_s]) begin
        if (!vld0) begin
          gnt0[idx_s] = 1'b1;
          vld0        = 1'b1;
        end else if (!vld1) begin
          gnt1[idx_s] = 1'b1;
          vld1        = 1'b1;
        end else begin
          vld1 = 1'b1;
        end
      end else begin
        idx_s = ptr + k[1:0];
      end
    end
  end

endmodule

// File: rtl/phy_tx_sched.sv
// Two-lane TX scheduler: link bring-up FSM, round-robin drain of four FWFT
// FIFOs, registered lane outputs. Optional tx_count port under TX_CNT_EN.
module phy_tx_sched
  import phy_tx_pkg::*;
#(
  parameter int            BW       = 8,
  parameter int            SYNC_LEN = 4,
  parameter logic [BW-1:0] COM_SYM  = BW'(COM_SYM_DEF),
  parameter logic [BW-1:0] IDL_SYM  = BW'(IDL_SYM_DEF)
) (
  input  logic          clk_2f,
  input  logic          reset_L,
  input  logic          enable,
  input  logic          hold,
  input  logic [3:0]    fifo_empty,
  input  logic [BW-1:0] fifo_data_0,
  input  logic [BW-1:0] fifo_data_1,
  input  logic [BW-1:0] fifo_data_2,
  input  logic [BW-1:0] fifo_data_3,
  output logic [3:0]    fifo_pop,
  output logic [BW-1:0] data_out_0,
  output logic [BW-1:0] data_out_1,
  output logic          valid_out_0,
  output logic          valid_out_1,
`ifdef TX_CNT_EN
  output logic [15:0]   tx_count,
`endif
  output logic          link_active
);

  localparam int CNT_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);

  link_state_e      state_r, state_nxt_s;
  logic [CNT_W-1:0] sync_cnt_r, sync_cnt_nxt_s;
  logic [1:0]       rr_ptr_r, rr_ptr_nxt_s;
  logic [BW-1:0]    d0_nxt_s, d1_nxt_s;
  logic             v0_nxt_s, v1_nxt_s, la_nxt_s;
  logic [3:0]       gnt0_s, gnt1_s;
  logic             vld0_s, vld1_s, grant_ok_s;
  logic [1:0]       idx0_s, idx1_s;
  logic [BW-1:0]    head_s [4];

  assign head_s[0] = fifo_data_0;
  assign head_s[1] = fifo_data_1;
  assign head_s[2] = fifo_data_2;
  assign head_s[3] = fifo_data_3;

  rr_pick2 u_pick (
    .req  (~fifo_empty),
    .ptr  (rr_ptr_r),
    .gnt0 (gnt0_s),
    .gnt1 (gnt1_s),
    .vld0 (vld0_s),
    .vld1 (vld1_s)
  );

  assign idx0_s = onehot_to_idx(gnt0_s);
  assign idx1_s = onehot_to_idx(gnt1_s);

  // Pops are only legal in ACTIVE with the link enabled and no backpressure.
  assign grant_ok_s = reset_L && enable && !hold && (state_r == ST_ACTIVE);
  assign fifo_pop   = grant_ok_s ? (gnt0_s | gnt1_s) : 4'b0000;

  // Next-state and next-output decode; output registers follow the state being entered.
  always_comb begin
    state_nxt_s    = state_r;
    sync_cnt_nxt_s = sync_cnt_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    d0_nxt_s       = {BW{1'b0}};
    d1_nxt_s       = {BW{1'b0}};
    v0_nxt_s       = 1'b0;
    v1_nxt_s       = 1'b0;
    la_nxt_s       = 1'b0;
    if (!enable) begin
      state_nxt_s = ST_DISABLED;
    end else begin
      case (state_r)
        ST_DISABLED: begin
          state_nxt_s    = ST_SYNC;
          sync_cnt_nxt_s = {CNT_W{1'b0}};
          d0_nxt_s       = COM_SYM;
          d1_nxt_s       = COM_SYM;
        end
        ST_SYNC: begin
          if (sync_cnt_r == SYNC_LAST) begin
            state_nxt_s = ST_ACTIVE;
            la_nxt_s    = 1'b1;
            d0_nxt_s    = IDL_SYM;
            d1_nxt_s    = IDL_SYM;
          end else begin
            sync_cnt_nxt_s = sync_cnt_r + CNT_W'(1);
            d0_nxt_s       = COM_SYM;
            d1_nxt_s       = COM_SYM;
          end
        end
        ST_ACTIVE: begin
          la_nxt_s = 1'b1;
          d0_nxt_s = IDL_SYM;
          d1_nxt_s = IDL_SYM;
          // The later grant in scan order sets the next starting point.
          if (grant_ok_s && vld0_s) begin
            d0_nxt_s     = head_s[idx0_s];
            v0_nxt_s     = 1'b1;
            rr_ptr_nxt_s = idx0_s + 2'd1;
            if (vld1_s) begin
              d1_nxt_s     = head_s[idx1_s];
              v1_nxt_s     = 1'b1;
              rr_ptr_nxt_s = idx1_s + 2'd1;
            end else begin
              v1_nxt_s = 1'b0;
            end
          end else begin
            rr_ptr_nxt_s = rr_ptr_r;
          end
        end
        default: begin
          state_nxt_s = ST_DISABLED;
        end
      endcase
    end
  end

  // State, pointer and registered output update.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_r     <= ST_DISABLED;
      sync_cnt_r  <= {CNT_W{1'b0}};
      rr_ptr_r    <= 2'd0;
      data_out_0  <= {BW{1'b0}};
      data_out_1  <= {BW{1'b0}};
      valid_out_0 <= 1'b0;
      valid_out_1 <= 1'b0;
      link_active <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sync_cnt_r  <= sync_cnt_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      data_out_0  <= d0_nxt_s;
      data_out_1  <= d1_nxt_s;
      valid_out_0 <= v0_nxt_s;
      valid_out_1 <= v1_nxt_s;
      link_active <= la_nxt_s;
    end
  end

`ifdef TX_CNT_EN
  // Payload byte counter, advanced alongside the valid flags it counts.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      tx_count <= 16'h0000;
    end else begin
      tx_count <= tx_count + {15'd0, v0_nxt_s} + {15'd0, v1_nxt_s};
    end
  end
`endif

endmodule

// File: tb/tb_phy_tx_sched.sv
// Directed table-driven bench for phy_tx_sched (default parameters);
// also checks tx_count when TX_CNT_EN is defined.
module tb_phy_tx_sched;

  logic       clk_2f = 1'b0;
  logic       reset_L = 1'b1;
  logic       enable = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] fifo_empty = 4'b1111;
  logic [7:0] fifo_data_0 = 8'h11;
  logic [7:0] fifo_data_1 = 8'h22;
  logic [7:0] fifo_data_2 = 8'h33;
  logic [7:0] fifo_data_3 = 8'h44;
  logic [3:0] fifo_pop;
  logic [7:0] data_out_0, data_out_1;
  logic       valid_out_0, valid_out_1, link_active;
`ifdef TX_CNT_EN
  logic [15:0] tx_count;
  logic [15:0] exp_cnt = 16'h0000;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  phy_tx_sched dut (
    .clk_2f      (clk_2f),
    .reset_L     (reset_L),
    .enable      (enable),
    .hold        (hold),
    .fifo_empty  (fifo_empty),
    .fifo_data_0 (fifo_data_0),
    .fifo_data_1 (fifo_data_1),
    .fifo_data_2 (fifo_data_2),
    .fifo_data_3 (fifo_data_3),
    .fifo_pop    (fifo_pop),
    .data_out_0  (data_out_0),
    .data_out_1  (data_out_1),
    .valid_out_0 (valid_out_0),
    .valid_out_1 (valid_out_1),
`ifdef TX_CNT_EN
    .tx_count    (tx_count),
`endif
    .link_active (link_active)
  );

  always #5 clk_2f = ~clk_2f;

  typedef struct {
    logic       en;
    logic       hd;
    logic [3:0] empty;
    logic [3:0] pop;
    logic [7:0] d0;
    logic       v0;
    logic [7:0] d1;
    logic       v1;
    logic       la;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic hd, input logic [3:0] empty, input logic [3:0] pop,
                     input logic [7:0] d0, input logic v0, input logic [7:0] d1, input logic v1,
                     input logic la);
    vec_t v;
    v = '{en, hd, empty, pop, d0, v0, d1, v1, la};
    vq.push_back(v);
  endtask

  initial begin
    // en hd empty    pop      d0     v0    d1     v1    la
    add(1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0); // 0 stay disabled
    add(1'b1, 1'b0, 4'b0000, 4'b0000, 8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0); // 1 enter SYNC
    add(1'b1, 1'b0, 4'b0000, 4'b0000, 8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0); // 2
    add(1'b1, 1'b0, 4'b0000, 4'b0000, 8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0); // 3
    add(1'b1, 1'b0, 4'b0000, 4'b0000, 8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0); // 4
    add(1'b1, 1'b0, 4'b0000, 4'b0000, 8'h7C, 1'b0, 8'h7C, 1'b0, 1'b1); // 5 ACTIVE
    add(1'b1, 1'b0, 4'b0000, 4'b0011, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1); // 6 rr 0 -> 2
    add(1'b1, 1'b0, 4'b0000, 4'b1100, 8'h33, 1'b1, 8'h44, 1'b1, 1'b1); // 7 rr 2 -> 0
    add(1'b1, 1'b0, 4'b0000, 4'b0011, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1); // 8 rr 0 -> 2
    add(1'b1, 1'b1, 4'b0000, 4'b0000, 8'h7C, 1'b0, 8'h7C, 1'b0, 1'b1); // 9 hold
    add(1'b1, 1'b0, 4'b1011, 4'b0100, 8'h33, 1'b1, 8'h7C, 1'b0, 1'b1); // 10 rr 2 -> 3
    add(1'b1, 1'b0, 4'b1011, 4'b0100, 8'h33, 1'b1, 8'h7C, 1'b0, 1'b1); // 11 rr 3 stays 3
    add(1'b1, 1'b0, 4'b0000, 4'b1001, 8'h44, 1'b1, 8'h11, 1'b1, 1'b1); // 12 wrap, rr -> 1
    add(1'b1, 1'b0, 4'b1111, 4'b0000, 8'h7C, 1'b0, 8'h7C, 1'b0, 1'b1); // 13 all empty
    add(1'b1, 1'b0, 4'b0101, 4'b1010, 8'h22, 1'b1, 8'h44, 1'b1, 1'b1); // 14 rr 1 -> 0
    add(1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0); // 15 enable drop
    add(1'b0, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0); // 16 enable wins over hold
    add(1'b1, 1'b1, 4'b0000, 4'b0000, 8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0); // 17 re-enter SYNC
    add(1'b1, 1'b0, 4'b0000, 4'b0000, 8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0); // 18
    add(1'b1, 1'b0, 4'b0000, 4'b0000, 8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0); // 19
    add(1'b1, 1'b0, 4'b0000, 4'b0000, 8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0); // 20
    add(1'b1, 1'b0, 4'b0000, 4'b0000, 8'h7C, 1'b0, 8'h7C, 1'b0, 1'b1); // 21 ACTIVE again
    add(1'b1, 1'b0, 4'b0000, 4'b0011, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1); // 22 rr kept at 0 -> 2

    // Power-on reset, checked without any clock edge
    #1 reset_L = 1'b0;
    #2;
    check("reset pop", {28'd0, fifo_pop}, 32'h0);
    check("reset outputs", {13'd0, data_out_0, valid_out_0, data_out_1, valid_out_1, link_active}, 32'h0);
    @(negedge clk_2f);
    reset_L = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk_2f);
      enable     = vq[i].en;
      hold       = vq[i].hd;
      fifo_empty = vq[i].empty;
      #1;
      check($sformatf("v%0d pop", i), {28'd0, fifo_pop}, {28'd0, vq[i].pop});
      @(posedge clk_2f);
      #1;
      check($sformatf("v%0d outputs", i),
            {13'd0, data_out_0, valid_out_0, data_out_1, valid_out_1, link_active},
            {13'd0, vq[i].d0, vq[i].v0, vq[i].d1, vq[i].v1, vq[i].la});
`ifdef TX_CNT_EN
      exp_cnt = exp_cnt + {15'd0, vq[i].v0} + {15'd0, vq[i].v1};
      check($sformatf("v%0d tx_count", i), {16'd0, tx_count}, {16'd0, exp_cnt});
`endif
    end

    // Asynchronous reset in the middle of ACTIVE with every FIFO non-empty
    @(negedge clk_2f);
    enable     = 1'b1;
    hold       = 1'b0;
    fifo_empty = 4'b0000;
    #1;
    check("pre-reset pop", {28'd0, fifo_pop}, 32'h0000000C);
    reset_L = 1'b0;
    #1;
    check("mid reset pop", {28'd0, fifo_pop}, 32'h0);
    check("mid reset outputs", {13'd0, data_out_0, valid_out_0, data_out_1, valid_out_1, link_active}, 32'h0);
`ifdef TX_CNT_EN
    check("mid reset tx_count", {16'd0, tx_count}, 32'h0);
`endif
    @(negedge clk_2f);
    enable  = 1'b0;
    reset_L = 1'b1;
    @(posedge clk_2f);
    #1;
    check("post reset outputs", {13'd0, data_out_0, valid_out_0, data_out_1, valid_out_1, link_active}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
